ifft_8_point: RTL and testbench



---
 rtl/ifft_8_point.sv | 180 ++++++++++++++++++
 tb/tb_ifft_8_point.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_8_point.sv
// ifft_8_point: registered 8-point radix-2 decimation-in-time inverse FFT.
//
// A full frame of eight complex bins is captured in parallel on an accepted
// start_ifft pulse. Three butterfly stages run on consecutive clock edges,
// and the time-domain result is published together with data_ready.
//
// Ports:
//   clk                     system clock, rising edge
//   rst                     asynchronous active-high reset
//   start_ifft              frame request, accepted only in IDLE or DONE
//   inK_i / inK_q (K=0..7)  frequency-domain bin K, signed IN_W bits
//   outN_i / outN_q (N=0..7) time-domain sample N, signed OUT_W bits, registered
//   data_ready              high while the outputs hold a completed frame
//
// Optional feature: define IFFT_SCALE_EN to scale every output by 1/8
// (rounded, (x + 4) >>> 3) inside the last register stage.
module ifft_8_point #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int TW_C  = 181
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_ifft,
    input  logic signed [IN_W-1:0]  in0_i, in0_q, in1_i, in1_q,
    input  logic signed [IN_W-1:0]  in2_i, in2_q, in3_i, in3_q,
    input  logic signed [IN_W-1:0]  in4_i, in4_q, in5_i, in5_q,
    input  logic signed [IN_W-1:0]  in6_i, in6_q, in7_i, in7_q,
    output logic signed [OUT_W-1:0] out0_i, out0_q, out1_i, out1_q,
    output logic signed [OUT_W-1:0] out2_i, out2_q, out3_i, out3_q,
    output logic signed [OUT_W-1:0] out4_i, out4_q, out5_i, out5_q,
    output logic signed [OUT_W-1:0] out6_i, out6_q, out7_i, out7_q,
    output logic                    data_ready
);
    typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

    state_t r_state, w_state_next;
    logic   w_accept;

    logic signed [IN_W-1:0]  w_in_i [8];
    logic signed [IN_W-1:0]  w_in_q [8];
    logic signed [OUT_W-1:0] w_cap_i [8], w_cap_q [8];
    logic signed [OUT_W-1:0] r_w_i [8],   r_w_q [8];     // working frame
    logic signed [OUT_W-1:0] w_s1_i [8],  w_s1_q [8];
    logic signed [OUT_W-1:0] w_s2_i [8],  w_s2_q [8];
    logic signed [OUT_W-1:0] w_z_i [8],   w_z_q [8];
    logic signed [OUT_W-1:0] r_out_i [8], r_out_q [8];

    // Multiply by 1/sqrt(2) in Q8 with round-half-up.
    function automatic logic signed [OUT_W-1:0] cmul(input logic signed [OUT_W:0] x);
        logic signed [31:0] p;
        p = 32'(x) * 32'(TW_C) + 32'sd128;
        return OUT_W'(p >>> 8);
    endfunction

    function automatic logic signed [OUT_W-1:0] out_fmt(input logic signed [OUT_W-1:0] x);
`ifdef IFFT_SCALE_EN
        return (x + OUT_W'(4)) >>> 3;
`else
        return x;
`endif
    endfunction

    assign w_in_i = '{in0_i, in1_i, in2_i, in3_i, in4_i, in5_i, in6_i, in7_i};
    assign w_in_q = '{in0_q, in1_q, in2_q, in3_q, in4_q, in5_q, in6_q, in7_q};

    genvar gi;
    generate
        // Capture: slot gi holds bin bitrev3(gi), sign-extended.
        for (gi = 0; gi < 8; gi++) begin : g_cap
            localparam int BR = ((gi & 1) << 2) | (gi & 2) | ((gi >> 2) & 1);
            assign w_cap_i[gi] = {{(OUT_W-IN_W){w_in_i[BR][IN_W-1]}}, w_in_i[BR]};
            assign w_cap_q[gi] = {{(OUT_W-IN_W){w_in_q[BR][IN_W-1]}}, w_in_q[BR]};
        end

        // Stage 1: 2-point butterflies on adjacent slots, no twiddle.
        for (gi = 0; gi < 4; gi++) begin : g_st1
            assign w_s1_i[2*gi]   = r_w_i[2*gi] + r_w_i[2*gi+1];
            assign w_s1_q[2*gi]   = r_w_q[2*gi] + r_w_q[2*gi+1];
            assign w_s1_i[2*gi+1] = r_w_i[2*gi] - r_w_i[2*gi+1];
            assign w_s1_q[2*gi+1] = r_w_q[2*gi] - r_w_q[2*gi+1];
        end

        // Stage 2: span 2; odd position in each group rotates by +j.
        for (gi = 0; gi < 4; gi++) begin : g_st2
            localparam int T  = 4 * (gi / 2) + (gi % 2);
            localparam int B  = T + 2;
            localparam bit RJ = (gi % 2) == 1;
            logic signed [OUT_W-1:0] w_tr, w_tq;
            assign w_tr = RJ ? -r_w_q[B] : r_w_i[B];
            assign w_tq = RJ ?  r_w_i[B] : r_w_q[B];
            assign w_s2_i[T] = r_w_i[T] + w_tr;
            assign w_s2_q[T] = r_w_q[T] + w_tq;
            assign w_s2_i[B] = r_w_i[T] - w_tr;
            assign w_s2_q[B] = r_w_q[T] - w_tq;
        end

        // Stage 3: span 4; lower half rotated by e^{j*pi*gi/4}.
        for (gi = 0; gi < 4; gi++) begin : g_st3
            logic signed [OUT_W:0]   w_sum, w_dif;
            logic signed [OUT_W-1:0] w_cs, w_cd, w_tr, w_tq;
            assign w_sum = {r_w_i[gi+4][OUT_W-1], r_w_i[gi+4]} + {r_w_q[gi+4][OUT_W-1], r_w_q[gi+4]};
            assign w_dif = {r_w_i[gi+4][OUT_W-1], r_w_i[gi+4]} - {r_w_q[gi+4][OUT_W-1], r_w_q[gi+4]};
            assign w_cs  = cmul(w_sum);
            assign w_cd  = cmul(w_dif);
            assign w_tr  = (gi == 0) ? r_w_i[gi+4] :
                           (gi == 1) ? w_cd :
                           (gi == 2) ? -r_w_q[gi+4] : -w_cs;
            assign w_tq  = (gi == 0) ? r_w_q[gi+4] :
                           (gi == 1) ? w_cs :
                           (gi == 2) ? r_w_i[gi+4] : w_cd;
            assign w_z_i[gi]   = out_fmt(r_w_i[gi] + w_tr);
            assign w_z_q[gi]   = out_fmt(r_w_q[gi] + w_tq);
            assign w_z_i[gi+4] = out_fmt(r_w_i[gi] - w_tr);
            assign w_z_q[gi+4] = out_fmt(r_w_q[gi] - w_tq);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start_ifft) begin
                    w_accept     = 1'b1;
                    w_state_next = S1;
                end
            end
            S1:      w_state_next = S2;
            S2:      w_state_next = S3;
            S3:      w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // One working register set is reused by all stages: each edge replaces
    // it with the next stage's result, S3 writes the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                r_w_i[k]   <= '0;
                r_w_q[k]   <= '0;
                r_out_i[k] <= '0;
                r_out_q[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_w_i <= w_cap_i;
                r_w_q <= w_cap_q;
            end else if (r_state == S1) begin
                r_w_i <= w_s1_i;
                r_w_q <= w_s1_q;
            end else if (r_state == S2) begin
                r_w_i <= w_s2_i;
                r_w_q <= w_s2_q;
            end else if (r_state == S3) begin
                r_out_i <= w_z_i;
                r_out_q <= w_z_q;
            end
        end
    end

    // DONE is left only by an accepted start or reset, so data_ready
    // clears exactly when a new frame is taken.
    assign data_ready = (r_state == DONE);

    assign out0_i = r_out_i[0];  assign out0_q = r_out_q[0];
    assign out1_i = r_out_i[1];  assign out1_q = r_out_q[1];
    assign out2_i = r_out_i[2];  assign out2_q = r_out_q[2];
    assign out3_i = r_out_i[3];  assign out3_q = r_out_q[3];
    assign out4_i = r_out_i[4];  assign out4_q = r_out_q[4];
    assign out5_i = r_out_i[5];  assign out5_q = r_out_q[5];
    assign out6_i = r_out_i[6];  assign out6_q = r_out_q[6];
    assign out7_i = r_out_i[7];  assign out7_q = r_out_q[7];
endmodule

// File: tb/tb_ifft_8_point.sv
// Scoreboard bench for ifft_8_point: stimulus pushes hand-computed frames,
// a negedge monitor pops and checks on every rising data_ready.
module tb_ifft_8_point;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_ifft = 1'b0;
    logic signed [7:0]  in_i [8];
    logic signed [7:0]  in_q [8];
    logic signed [15:0] out_i [8];
    logic signed [15:0] out_q [8];
    logic data_ready;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    ifft_8_point dut (
        .clk(clk), .rst(rst), .start_ifft(start_ifft),
        .in0_i(in_i[0]), .in0_q(in_q[0]), .in1_i(in_i[1]), .in1_q(in_q[1]),
        .in2_i(in_i[2]), .in2_q(in_q[2]), .in3_i(in_i[3]), .in3_q(in_q[3]),
        .in4_i(in_i[4]), .in4_q(in_q[4]), .in5_i(in_i[5]), .in5_q(in_q[5]),
        .in6_i(in_i[6]), .in6_q(in_q[6]), .in7_i(in_i[7]), .in7_q(in_q[7]),
        .out0_i(out_i[0]), .out0_q(out_q[0]), .out1_i(out_i[1]), .out1_q(out_q[1]),
        .out2_i(out_i[2]), .out2_q(out_q[2]), .out3_i(out_i[3]), .out3_q(out_q[3]),
        .out4_i(out_i[4]), .out4_q(out_q[4]), .out5_i(out_i[5]), .out5_q(out_q[5]),
        .out6_i(out_i[6]), .out6_q(out_q[6]), .out7_i(out_i[7]), .out7_q(out_q[7]),
        .data_ready(data_ready)
    );

    // Frames: [2k] = real, [2k+1] = imag of bin k / sample k.
    // 0 impulse, 1 DC, 2 bin2 j50, 3 Nyquist, 4 diagonal, 5 impulse+bin2, 6 negative Nyquist
    int in_tab [7][16] = '{
        '{127,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0},
        '{10,0, 10,0, 10,0, 10,0, 10,0, 10,0, 10,0, 10,0},
        '{0,0, 0,0, 0,50, 0,0, 0,0, 0,0, 0,0, 0,0},
        '{0,0, 0,0, 0,0, 0,0, 100,0, 0,0, 0,0, 0,0},
        '{0,0, 64,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0},
        '{127,0, 0,0, 0,50, 0,0, 0,0, 0,0, 0,0, 0,0},
        '{0,0, 0,0, 0,0, 0,0, -100,0, 0,0, 0,0, 0,0}
    };
    int exp_tab [7][16] = '{
        '{127,0, 127,0, 127,0, 127,0, 127,0, 127,0, 127,0, 127,0},
        '{80,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0},
        '{0,50, -50,0, 0,-50, 50,0, 0,50, -50,0, 0,-50, 50,0},
        '{100,0, -100,0, 100,0, -100,0, 100,0, -100,0, 100,0, -100,0},
        '{64,0, 45,45, 0,64, -45,45, -64,0, -45,-45, 0,-64, 45,-45},
        '{127,50, 77,0, 127,-50, 177,0, 127,50, 77,0, 127,-50, 177,0},
        '{-100,0, 100,0, -100,0, 100,0, -100,0, 100,0, -100,0, 100,0}
    };

    typedef struct {
        logic [7:0][15:0] ei;
        logic [7:0][15:0] eq;
        int id;
        int due;
    } exp_t;
    exp_t sb[$];

    function automatic logic [15:0] expv(input int v);
`ifdef IFFT_SCALE_EN
        return 16'((v + 4) >>> 3);
`else
        return 16'(v);
`endif
    endfunction

    task automatic load(input int f);
        for (int k = 0; k < 8; k++) begin
            in_i[k] = 8'(in_tab[f][2*k]);
            in_q[k] = 8'(in_tab[f][2*k+1]);
        end
    endtask

    // acc_edge: edge_cnt value right after the accepting edge.
    task automatic push(input int f, input int acc_edge);
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            e.ei[n] = expv(exp_tab[f][2*n]);
            e.eq[n] = expv(exp_tab[f][2*n+1]);
        end
        e.id  = f;
        e.due = acc_edge + 3;
        sb.push_back(e);
    endtask

    task automatic issue(input int f);
        @(negedge clk);
        load(f);
        start_ifft = 1'b1;
        push(f, edge_cnt + 1);
        @(negedge clk);
        start_ifft = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (out_i[n] !== 16'sd0 || out_q[n] !== 16'sd0) begin
                n_fail++;
                $display("FAIL %s out%0d got (%0d,%0d) want (0,0)", tag, n, out_i[n], out_q[n]);
            end
        end
        n_cmp++;
        if (data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s data_ready got %b want 0", tag, data_ready);
        end
        $display("%s: outputs/data_ready checked for zero", tag);
    endtask

    // Monitor: one frame check per rising data_ready.
    initial begin
        logic dr_prev;
        exp_t e;
        int bad;
        dr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && data_ready === 1'b1 && !dr_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result data_ready rose with no frame pending");
                end else begin
                    e = sb.pop_front();
                    bad = 0;
                    n_cmp++;
                    if (edge_cnt != e.due) begin
                        n_fail++; bad++;
                        $display("FAIL latency frame %0d ready at edge %0d want %0d", e.id, edge_cnt, e.due);
                    end
                    for (int n = 0; n < 8; n++) begin
                        n_cmp += 2;
                        if (out_i[n] !== $signed(e.ei[n])) begin
                            n_fail++; bad++;
                            $display("FAIL frame %0d out%0d_i got %0d want %0d", e.id, n, out_i[n], $signed(e.ei[n]));
                        end
                        if (out_q[n] !== $signed(e.eq[n])) begin
                            n_fail++; bad++;
                            $display("FAIL frame %0d out%0d_q got %0d want %0d", e.id, n, out_q[n], $signed(e.eq[n]));
                        end
                    end
                    $display("frame %0d: out0=(%0d,%0d) out1=(%0d,%0d) errors=%0d",
                             e.id, out_i[0], out_q[0], out_i[1], out_q[1], bad);
                end
            end
            dr_prev = (data_ready === 1'b1);
        end
    end

    initial begin
        load(0);
        for (int k = 0; k < 8; k++) begin in_i[k] = '0; in_q[k] = '0; end
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        // Directed frames.
        for (int f = 0; f < 7; f++) begin
            issue(f);
            repeat (5) @(negedge clk);
        end

        // Start pulse while in S2 must be ignored.
        @(negedge clk);
        load(4);
        start_ifft = 1'b1;
        push(4, edge_cnt + 1);
        @(negedge clk);                 // after E0, in S1
        start_ifft = 1'b0;
        load(1);
        @(negedge clk);                 // after E1, in S2
        start_ifft = 1'b1;
        load(0);
        @(negedge clk);                 // E2 saw start in S2
        start_ifft = 1'b0;
        repeat (5) @(negedge clk);

        // Start held high: accepted at E0 and again at E4 (from DONE).
        @(negedge clk);
        load(2);
        start_ifft = 1'b1;
        push(2, edge_cnt + 1);
        @(negedge clk);                 // after E0
        load(3);
        push(3, edge_cnt + 4);
        repeat (4) @(negedge clk);      // after E4
        start_ifft = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during S2 aborts the frame and clears outputs at once.
        @(negedge clk);
        load(1);
        start_ifft = 1'b1;
        @(negedge clk);
        start_ifft = 1'b0;
        @(negedge clk);                 // in S2
        rst = 1'b1;
        #1;
        check_zero("reset_in_s2");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_frame data_ready got %b want 0", data_ready);
        end
        issue(5);
        repeat (6) @(negedge clk);

        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_frames got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
